fir_mac_engine: RTL
===================

FIR_MAC_ENGINE -- requirements
Module: fir_mac_engine

Interface
REQ-001 SHALL have parameter NTAPS, default 4, number of FIR taps and window depth (range 2..256).
REQ-002 SHALL have parameter CW, default 16, signed coefficient width.
REQ-003 SHALL have parameter OUT_W, default 34, result width.
REQ-004 SHALL have parameter SHIFT, default 0, arithmetic right shift applied to the accumulator before output.
REQ-005 SHALL have derived localparam ACC_W = 16 + CW + clog2(NTAPS), the accumulator width.
REQ-006 clk  input  1  the only clock; all state changes on its rising edge.
REQ-007 reset  input  1  asynchronous, active-low reset.
REQ-008 sample_valid  input  1  a new ADC sample is present this cycle.
REQ-009 sample  input  24  ADC word; only bits [23:8] are used, as an unsigned 16-bit sample.
REQ-010 coeff_we  input  1  coefficient write strobe.
REQ-011 coeff_addr  input  clog2(NTAPS)  tap index to write.
REQ-012 coeff_wdata  input  CW  signed coefficient value.
REQ-013 overrun_clr  input  1  clears the overrun flag.
REQ-014 result  output  OUT_W  signed filter output.
REQ-015 result_valid  output  1  one-cycle pulse marking a valid result.
REQ-016 busy  output  1  high whenever the state is not IDLE.
REQ-017 overrun  output  1  sticky flag: a sample was dropped.

Function
REQ-018 SHALL hold NTAPS coefficients in a register bank; window[0] is the newest sample and window[NTAPS-1] the oldest.
REQ-019 FSM SHALL have three states: IDLE, MAC and OUT. IDLE goes to MAC on sample_valid. MAC goes to OUT after NTAPS cycles. OUT goes to IDLE after one cycle.
REQ-020 On sample_valid in IDLE, the same edge SHALL shift the window by one position, load sample[23:8] into window[0], clear the accumulator and clear the tap counter k.
REQ-021 In MAC, each cycle SHALL add signed(coeff[k]) * unsigned(window[k]) to the accumulator, sign-extended to ACC_W, then increment k.
REQ-022 In OUT, result SHALL be driven from the shifted accumulator and result_valid SHALL be 1 for exactly one cycle.
REQ-023 result SHALL hold its value until the next OUT state.
REQ-024 Latency SHALL be fixed: sample_valid accepted at edge 0 gives result_valid high in cycle NTAPS+1.
REQ-025 A sample_valid arriving in MAC or OUT SHALL be dropped, leaving the window unchanged, and SHALL set overrun.
REQ-026 overrun_clr SHALL clear overrun. If overrun_clr coincides with a drop, the flag SHALL end set (set wins).
REQ-027 A coeff_we in IDLE SHALL write coeff[coeff_addr] on that edge.
REQ-028 A coeff_we while busy SHALL be ignored, so a running computation always uses a consistent coefficient set.
REQ-029 The accumulator SHALL never overflow, because ACC_W covers the worst case of NTAPS full-scale products.

Reset
REQ-030 While reset=0, SHALL return to IDLE immediately, including mid-MAC, with no result_valid for the aborted sample.
REQ-031 While reset=0, SHALL hold result=0, result_valid=0, busy=0 and overrun=0.
REQ-032 While reset=0, SHALL hold all window entries, the accumulator and k at 0.
REQ-033 While reset=0, SHALL hold all coefficients at 0.
REQ-034 The first rising clk edge after reset deasserts SHALL be able to accept a sample.

Configuration
REQ-035 Macro FIR_SATURATE_EN defined: result SHALL be (acc >>> SHIFT) clamped to the signed OUT_W range, [-2^(OUT_W-1), 2^(OUT_W-1)-1].
REQ-036 Macro FIR_SATURATE_EN undefined: result SHALL be the low OUT_W bits of (acc >>> SHIFT), so results wrap on overflow.

Structure
REQ-037 Package fir_pkg SHALL hold the FSM state enum type fir_state_t, the default parameter constants and the clog2 helper function.
REQ-038 The sample window SHALL be a sub-module named fir_window (parameter NTAPS; ports clk, reset, shift_en, din[15:0], packed window array output).
REQ-039 The FSM, MAC datapath, coefficient bank and output stage SHALL stay in fir_mac_engine.

Verification (NTAPS=4, CW=16, SHIFT=0 unless noted)
REQ-040 Tap sum: coeff={1,2,3,4} (k=0..3); feed samples 24'h000100, 24'h000200, 24'h000300, 24'h000400, each after the previous result -> 4th result = 20; result_valid exactly 5 cycles after acceptance.
REQ-041 Signed coefficient: coeff[0]=16'hFFFF, others 0; sample 24'hFFFF00 -> result = -65535.
REQ-042 Overrun: second sample_valid 2 cycles after the first -> result matches the first sample alone; overrun=1.
REQ-043 Overrun clear: pulse overrun_clr after REQ-042 -> overrun=0.
REQ-044 Saturation: OUT_W=16; all coeffs 16'h7FFF; four samples 24'hFFFF00 -> 4th result = 16'h7FFF with FIR_SATURATE_EN defined, 16'h0004 without it.
REQ-045 Reset mid-operation: reset low during MAC cycle 2 -> busy=0 and no result_valid. Then after re-release, load coeff={1,2,3,4} and feed 24'h000100 -> result = 1.
REQ-046 Coefficient write while busy: coeff_we during MAC -> coefficient unchanged; the next result uses the old value.

Source files
------------

// File: rtl/fir_pkg.sv
// Shared definitions for the FIR multiply-accumulate engine: FSM state
// encoding, default parameter values and the clog2 helper used to size
// address and accumulator fields.
package fir_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_OUT  = 2'd2
  } fir_state_t;

  localparam int FIR_NTAPS_DEF = 4;
  localparam int FIR_CW_DEF    = 16;
  localparam int FIR_OUT_W_DEF = 34;
  localparam int FIR_SHIFT_DEF = 0;
  localparam int FIR_SAMPLE_W  = 16;

  // Smallest r with 2**r >= n.
  function automatic int fir_clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/fir_window.sv
// Sample delay line for the FIR engine. window[0] holds the newest sample and
// window[NTAPS-1] the oldest; one shift per accepted sample.
module fir_window
  import fir_pkg::*;
#(
  parameter int NTAPS = FIR_NTAPS_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   shift_en,
  input  logic [15:0]            din,
  output logic [NTAPS-1:0][15:0] window
);

  // Shift every entry one position older and load the new sample at index 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      window <= '0;
    end else if (shift_en) begin
      window <= {window[NTAPS-2:0], din};
    end
  end

endmodule

// File: rtl/fir_mac_engine.sv
// Serial FIR filter: one multiply-accumulate per clock over NTAPS taps.
// Optional build macro FIR_SATURATE_EN clamps the output to the signed OUT_W
// range; without it the output is the low OUT_W bits of the shifted sum.
//
// Sample handshake: a sample is taken when sample_valid is high and busy is
// low on the same rising edge. sample_valid while busy is never back-pressured;
// that sample is discarded (window untouched) and the sticky overrun flag set.
module fir_mac_engine
  import fir_pkg::*;
#(
  parameter int NTAPS = FIR_NTAPS_DEF,
  parameter int CW    = FIR_CW_DEF,
  parameter int OUT_W = FIR_OUT_W_DEF,
  parameter int SHIFT = FIR_SHIFT_DEF
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         sample_valid,
  input  logic [23:0]                  sample,
  input  logic                         coeff_we,
  input  logic [fir_clog2(NTAPS)-1:0]  coeff_addr,
  input  logic signed [CW-1:0]         coeff_wdata,
  input  logic                         overrun_clr,
  output logic [OUT_W-1:0]             result,
  output logic                         result_valid,
  output logic                         busy,
  output logic                         overrun,
  output logic [1:0]                   dbg_state
);

  localparam int AW    = fir_clog2(NTAPS);
  localparam int ACC_W = FIR_SAMPLE_W + CW + AW;
  localparam int WW    = (ACC_W > OUT_W) ? ACC_W : OUT_W;
  localparam logic [AW-1:0] K_LAST = AW'(NTAPS - 1);

  fir_state_t                state;
  logic [AW-1:0]             k;
  logic signed [ACC_W-1:0]   acc;
  logic signed [ACC_W-1:0]   acc_next;
  logic signed [ACC_W-1:0]   acc_shift;
  logic signed [ACC_W-1:0]   prod;
  logic signed [CW-1:0]      coeff [NTAPS];
  logic signed [CW-1:0]      coeff_k;
  logic signed [16:0]        win_k;
  logic signed [WW-1:0]      acc_wide;
  logic [OUT_W-1:0]          res_d;
  logic [NTAPS-1:0][15:0]    window;
  logic                      accept;
  logic                      drop;
  logic                      last_tap;
  logic                      addr_ok;
  logic                      unused_sample_lsbs;

  assign accept   = sample_valid && (state == ST_IDLE);
  assign drop     = sample_valid && (state != ST_IDLE);
  assign last_tap = (state == ST_MAC) && (k == K_LAST);
  assign addr_ok  = {1'b0, coeff_addr} < (AW + 1)'(NTAPS);
  assign busy     = (state != ST_IDLE);
  assign dbg_state = state;
  assign unused_sample_lsbs = ^sample[7:0];

  fir_window #(
    .NTAPS (NTAPS)
  ) u_window (
    .clk      (clk),
    .reset    (reset),
    .shift_en (accept),
    .din      (sample[23:8]),
    .window   (window)
  );

  // Signed coefficient times zero-extended unsigned sample, sign-extended to
  // the accumulator width before the add.
  assign coeff_k   = coeff[k];
  assign win_k     = $signed({1'b0, window[k]});
  assign prod      = ACC_W'(coeff_k) * ACC_W'(win_k);
  assign acc_next  = acc + prod;
  assign acc_shift = acc_next >>> SHIFT;
  assign acc_wide  = WW'(acc_shift);

`ifdef FIR_SATURATE_EN
  localparam logic signed [WW-1:0] SAT_MAX = {{(WW - OUT_W + 1){1'b0}}, {(OUT_W - 1){1'b1}}};
  localparam logic signed [WW-1:0] SAT_MIN = {{(WW - OUT_W + 1){1'b1}}, {(OUT_W - 1){1'b0}}};

  // Clamp the shifted sum into the signed OUT_W range.
  always_comb begin
    res_d = acc_wide[OUT_W-1:0];
    if (acc_wide > SAT_MAX) begin
      res_d = SAT_MAX[OUT_W-1:0];
    end else if (acc_wide < SAT_MIN) begin
      res_d = SAT_MIN[OUT_W-1:0];
    end
  end
`else
  assign res_d = acc_wide[OUT_W-1:0];
`endif

  // Control FSM, tap counter and accumulator.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
      k     <= '0;
      acc   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (sample_valid) begin
            state <= ST_MAC;
            k     <= '0;
            acc   <= '0;
          end
        end
        ST_MAC: begin
          acc <= acc_next;
          if (k == K_LAST) begin
            state <= ST_OUT;
          end else begin
            k <= k + 1'b1;
          end
        end
        ST_OUT: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Output register: loads on the final tap so result_valid lines up with OUT.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      result       <= '0;
      result_valid <= 1'b0;
    end else begin
      result_valid <= last_tap;
      if (last_tap) begin
        result <= res_d;
      end
    end
  end

  // Sticky overrun flag; a drop on the same edge as a clear keeps it set.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overrun <= 1'b0;
    end else if (drop) begin
      overrun <= 1'b1;
    end else if (overrun_clr) begin
      overrun <= 1'b0;
    end
  end

  // Coefficient bank: writable only while idle so a running sum never mixes sets.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NTAPS; i++) begin
        coeff[i] <= '0;
      end
    end else if (coeff_we && (state == ST_IDLE) && addr_ok) begin
      coeff[coeff_addr] <= coeff_wdata;
    end
  end

endmodule
